// File: rtl/uu_wlan_tx_frame_feeder.sv
// uu_wlan_tx_frame_feeder
//
// MAC-side transmit sequencer in the wr_clk domain, feeding the tx FIFO block.
// A tx_req latches a TXVECTOR and a PSDU byte count. The block then issues
// txstart_req and streams the TXVECTOR bytes. After the PHY start confirm it
// forwards PSDU bytes from a valid/ready source, one per granted
// txdata_confirm. It closes with txend_req and reports tx_done or tx_err.
//
// Optional feature: define UU_WLAN_TX_TIMEOUT_EN to add a confirm watchdog.
// Its limit is the TIMEOUT_CYC parameter, which exists only in that build.
//
// Ports:
//   wr_clk, rst                  clock; asynchronous active-high reset
//   tx_req, tx_abort             1-cycle control pulses from MAC control
//   txvector, frame_len          frame descriptor, sampled on an accepted tx_req
//   src_data/src_valid/src_ready PSDU byte source (src_ready is combinational)
//   fifo2mac_*_confirm           PHY-side handshakes from the FIFO block
//   mac2fifo_*                   registered request/data outputs to the FIFO
//   tx_busy                      high in every state except IDLE
//   tx_done, tx_err              registered 1-cycle completion pulses
//   state_dbg                    current FSM state, for debug and checkers
//
// Source handshake: a byte moves when src_valid and src_ready are both high
// in the same cycle. src_ready is never high unless a data confirm is present,
// so a byte is consumed only when the PHY has granted a slot for it.

module uu_wlan_tx_frame_feeder #(
  parameter int TXVEC_LEN = 33,
  parameter int LEN_W     = 16
`ifdef UU_WLAN_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic                   tx_req,
  input  logic                   tx_abort,
  input  logic [TXVEC_LEN*8-1:0] txvector,
  input  logic [LEN_W-1:0]       frame_len,
  input  logic [7:0]             src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic                   fifo2mac_txstart_confirm,
  input  logic                   fifo2mac_txdata_confirm,
  input  logic                   fifo2mac_txend_confirm,
  output logic                   mac2fifo_txstart_req,
  output logic                   mac2fifo_frame_val,
  output logic [7:0]             mac2fifo_phy_frame,
  output logic                   mac2fifo_txend_req,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_err,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VEC       = 3'd1,
    S_WAIT_SCFM = 3'd2,
    S_DATA      = 3'd3,
    S_END       = 3'd4,
    S_WAIT_ECFM = 3'd5
  } state_t;

  localparam int VEC_W = TXVEC_LEN * 8;
  localparam int IDX_W = (TXVEC_LEN > 1) ? $clog2(TXVEC_LEN) : 1;

  state_t           state;
  logic [VEC_W-1:0] vec_reg;
  logic [VEC_W-1:0] vec_shift;
  logic [LEN_W-1:0] remain;
  logic [IDX_W-1:0] idx;
  logic             abort_flag;
  logic             tmo_hit;

  // The TXVECTOR is shifted down one byte per VEC cycle, so the byte to
  // present next is always in the low byte of the shifted value.
  assign vec_shift = vec_reg >> 8;

  // An abort takes effect in its own cycle: no byte is pulled from the source.
  assign src_ready = (state == S_DATA) & fifo2mac_txdata_confirm & src_valid &
                     (remain != '0) & ~tx_abort;

  assign tx_busy   = (state != S_IDLE);
  assign state_dbg = state;

`ifdef UU_WLAN_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_count;

  // The counter runs only while the block is waiting on the PHY. Any cycle
  // in which it is not counting clears it, so every state entry starts from
  // zero. A granted data slot also clears it: the watchdog measures a
  // stalled PHY, not the length of a frame.
  assign tmo_count = ((state == S_WAIT_SCFM) & ~fifo2mac_txstart_confirm) |
                     ((state == S_WAIT_ECFM) & ~fifo2mac_txend_confirm)   |
                     ((state == S_DATA)      & ~fifo2mac_txdata_confirm);
  assign tmo_hit   = tmo_count & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (tmo_count && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      vec_reg              <= '0;
      remain               <= '0;
      idx                  <= '0;
      abort_flag           <= 1'b0;
      mac2fifo_txstart_req <= 1'b0;
      mac2fifo_frame_val   <= 1'b0;
      mac2fifo_phy_frame   <= 8'h00;
      mac2fifo_txend_req   <= 1'b0;
      tx_done              <= 1'b0;
      tx_err               <= 1'b0;
    end else begin
      // Request and completion outputs are single-cycle pulses.
      mac2fifo_txstart_req <= 1'b0;
      mac2fifo_txend_req   <= 1'b0;
      tx_done              <= 1'b0;
      tx_err               <= 1'b0;

      case (state)
        S_IDLE: begin
          mac2fifo_frame_val <= 1'b0;
          mac2fifo_phy_frame <= 8'h00;
          if (tx_req) begin
            vec_reg              <= txvector;
            remain               <= frame_len;
            idx                  <= '0;
            abort_flag           <= 1'b0;
            // The first VEC cycle already shows txstart_req and byte 0.
            mac2fifo_txstart_req <= 1'b1;
            mac2fifo_frame_val   <= 1'b1;
            mac2fifo_phy_frame   <= txvector[7:0];
            state                <= S_VEC;
          end
        end

        S_VEC: begin
          if (tx_abort) begin
            abort_flag         <= 1'b1;
            mac2fifo_frame_val <= 1'b0;
            mac2fifo_phy_frame <= 8'h00;
            mac2fifo_txend_req <= 1'b1;
            state              <= S_END;
          end else if (idx == IDX_W'(TXVEC_LEN - 1)) begin
            mac2fifo_frame_val <= 1'b0;
            mac2fifo_phy_frame <= 8'h00;
            state              <= S_WAIT_SCFM;
          end else begin
            idx                <= idx + IDX_W'(1);
            vec_reg            <= vec_shift;
            mac2fifo_phy_frame <= vec_shift[7:0];
          end
        end

        S_WAIT_SCFM: begin
          if (tx_abort || tmo_hit) begin
            abort_flag         <= 1'b1;
            mac2fifo_txend_req <= 1'b1;
            state              <= S_END;
          end else if (fifo2mac_txstart_confirm) begin
            if (remain != '0) begin
              state <= S_DATA;
            end else begin
              mac2fifo_txend_req <= 1'b1;
              state              <= S_END;
            end
          end
        end

        S_DATA: begin
          if (tx_abort || tmo_hit) begin
            abort_flag         <= 1'b1;
            mac2fifo_frame_val <= 1'b0;
            mac2fifo_phy_frame <= 8'h00;
            mac2fifo_txend_req <= 1'b1;
            state              <= S_END;
          end else if (remain == '0) begin
            // The last byte is on the outputs this cycle; END follows it.
            mac2fifo_frame_val <= 1'b0;
            mac2fifo_phy_frame <= 8'h00;
            mac2fifo_txend_req <= 1'b1;
            state              <= S_END;
          end else if (src_ready) begin
            mac2fifo_frame_val <= 1'b1;
            mac2fifo_phy_frame <= src_data;
            remain             <= remain - LEN_W'(1);
          end else begin
            mac2fifo_frame_val <= 1'b0;
            mac2fifo_phy_frame <= 8'h00;
          end
        end

        S_END: begin
          mac2fifo_frame_val <= 1'b0;
          mac2fifo_phy_frame <= 8'h00;
          state              <= S_WAIT_ECFM;
        end

        S_WAIT_ECFM: begin
          if (fifo2mac_txend_confirm) begin
            tx_done    <= ~abort_flag;
            tx_err     <= abort_flag;
            abort_flag <= 1'b0;
            state      <= S_IDLE;
          end else if (tmo_hit) begin
            tx_err     <= 1'b1;
            abort_flag <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uu_wlan_tx_frame_feeder.sv
// Testbench for uu_wlan_tx_frame_feeder: directed frames with an event
// scoreboard. The driver pushes the expected event stream (start, every
// frame byte, end, done/err) into exp_q. A negedge monitor turns DUT outputs
// into the same event tokens, pops and compares.

module tb_uu_wlan_tx_frame_feeder;

  localparam int TXVEC_LEN = 33;
  localparam int LEN_W     = 16;
  localparam int W         = 11;

  localparam logic [2:0] K_START = 3'd1;
  localparam logic [2:0] K_BYTE  = 3'd2;
  localparam logic [2:0] K_END   = 3'd3;
  localparam logic [2:0] K_DONE  = 3'd4;
  localparam logic [2:0] K_ERR   = 3'd5;

  logic                   wr_clk;
  logic                   rst;
  logic                   tx_req;
  logic                   tx_abort;
  logic [TXVEC_LEN*8-1:0] txvector;
  logic [LEN_W-1:0]       frame_len;
  logic [7:0]             src_data;
  logic                   src_valid;
  logic                   src_ready;
  logic                   scfm;
  logic                   data_cfm;
  logic                   ecfm;
  logic                   txstart_req;
  logic                   frame_val;
  logic [7:0]             phy_frame;
  logic                   txend_req;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   tx_err;
  logic [2:0]             state_dbg;

  uu_wlan_tx_frame_feeder #(
    .TXVEC_LEN(TXVEC_LEN),
    .LEN_W(LEN_W)
`ifdef UU_WLAN_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(64)
`endif
  ) dut (
    .wr_clk(wr_clk),
    .rst(rst),
    .tx_req(tx_req),
    .tx_abort(tx_abort),
    .txvector(txvector),
    .frame_len(frame_len),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .fifo2mac_txstart_confirm(scfm),
    .fifo2mac_txdata_confirm(data_cfm),
    .fifo2mac_txend_confirm(ecfm),
    .mac2fifo_txstart_req(txstart_req),
    .mac2fifo_frame_val(frame_val),
    .mac2fifo_phy_frame(phy_frame),
    .mac2fifo_txend_req(txend_req),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   src_q[$];
  int vectors    = 0;
  int miscompares = 0;

  int vec_seen, data_seen, src_taken, cur_len, popped, gap_at, hold_cnt, pat_ctr;
  int cfm_mode;
  bit end_seen, done_seen, in_data, p_in_data, p_rdy, took;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic obs(input logic [2:0] kind, input logic [7:0] b);
    logic [W-1:0] tok;
    logic [W-1:0] e;
    tok = {kind, b};
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'(tok), 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("event_seq", 32'(tok), 32'(e));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge wr_clk) begin
    bit exp_rdy;
    if (!rst) begin
      exp_rdy = in_data && data_cfm && src_valid && (src_taken < cur_len);
      check("src_ready", 32'(src_ready), 32'(exp_rdy));
      if (p_in_data) check("frame_val_follow", 32'(frame_val), 32'(p_rdy));
      p_in_data = in_data;
      p_rdy     = exp_rdy;
      if (txstart_req) obs(K_START, 8'h00);
      if (frame_val) begin
        obs(K_BYTE, phy_frame);
        if (vec_seen < TXVEC_LEN) vec_seen++;
        else data_seen++;
      end
      if (txend_req) begin
        obs(K_END, 8'h00);
        check("end_frame_val", 32'(frame_val), 32'h0);
        check("end_phy_frame", 32'(phy_frame), 32'h0);
        end_seen = 1;
      end
      if (tx_done) begin obs(K_DONE, 8'h00); done_seen = 1; end
      if (tx_err)  begin obs(K_ERR, 8'h00);  done_seen = 1; end
      if (src_ready) src_taken++;
      took = src_ready;
    end else begin
      took      = 0;
      p_in_data = 0;
    end
  end

  // ---------------- byte source and data-confirm drivers ----------------
  always @(posedge wr_clk) begin
    #1;
    if (hold_cnt > 0) hold_cnt--;
    if (took && src_q.size() > 0) begin
      void'(src_q.pop_front());
      popped++;
      if (popped == gap_at) hold_cnt = 3;
    end
    src_valid = (src_q.size() > 0) && (hold_cnt == 0);
    src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    data_cfm  = (cfm_mode == 0) ? 1'b1 : (pat_ctr < 7);
    pat_ctr   = (pat_ctr + 1) % 18;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_tx_req();
    @(posedge wr_clk); #1 tx_req = 1'b1;
    @(posedge wr_clk); #1 tx_req = 1'b0;
  endtask

  function automatic logic [7:0] vbyte(input int seed, input int i);
    return 8'((i * 5 + seed * 17 + 3) & 255);
  endfunction

  function automatic logic [7:0] dbyte(input int seed, input int i);
    return 8'((8'hA0 + i * 3 + seed * 29) & 255);
  endfunction

  task automatic prep_frame(input int len, input int seed);
    for (int i = 0; i < TXVEC_LEN; i++) txvector[i*8 +: 8] = vbyte(seed, i);
    frame_len = LEN_W'(len);
    vec_seen = 0; data_seen = 0; src_taken = 0; popped = 0;
    end_seen = 0; done_seen = 0; cur_len = len;
    exp_q.push_back({K_START, 8'h00});
    for (int i = 0; i < TXVEC_LEN; i++) exp_q.push_back({K_BYTE, vbyte(seed, i)});
  endtask

  // abort_at: data byte number during which tx_abort is pulsed (0 = none)
  task automatic run_frame(input int len, input int abort_at, input int gap,
                           input int mode, input int seed);
    int nbytes;
    cfm_mode = mode;
    gap_at   = gap;
    nbytes   = (abort_at > 0) ? abort_at : len;
    prep_frame(len, seed);
    for (int i = 0; i < len; i++) src_q.push_back(dbyte(seed, i));
    for (int i = 0; i < nbytes; i++) exp_q.push_back({K_BYTE, dbyte(seed, i)});
    exp_q.push_back({K_END, 8'h00});
    exp_q.push_back((abort_at > 0) ? {K_ERR, 8'h00} : {K_DONE, 8'h00});

    pulse_tx_req();
    for (int n = 0; n < 200 && vec_seen < TXVEC_LEN; n++) @(posedge wr_clk);
    check("vec_bytes", 32'(vec_seen), 32'(TXVEC_LEN));
    #1 scfm = 1'b1;
    @(posedge wr_clk); #1 scfm = 1'b0; in_data = 1;
    if (len == 0) begin
      @(negedge wr_clk);
      check("len0_txend_next", 32'(txend_req), 32'h1);
    end
    if (abort_at > 0) begin
      for (int n = 0; n < 200 && data_seen < abort_at - 1; n++) @(posedge wr_clk);
      check("abort_point", 32'(data_seen), 32'(abort_at - 1));
      #1 tx_abort = 1'b1; in_data = 0;
      @(posedge wr_clk); #1 tx_abort = 1'b0;
    end
    for (int n = 0; n < 500 && !end_seen; n++) @(posedge wr_clk);
    check("end_seen", 32'(end_seen), 32'h1);
    in_data = 0;
    if (abort_at > 0) pulse_tx_req();  // must be ignored while busy
    repeat (2) @(posedge wr_clk);
    #1 ecfm = 1'b1;
    @(posedge wr_clk); #1 ecfm = 1'b0;
    for (int n = 0; n < 10 && !done_seen; n++) @(posedge wr_clk);
    check("done_seen", 32'(done_seen), 32'h1);
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    check("idle_busy", 32'(tx_busy), 32'h0);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("src_taken", 32'(src_taken), 32'(nbytes));
    @(posedge wr_clk); #1;
    src_q.delete();
    hold_cnt = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; tx_req = 1'b0; tx_abort = 1'b0; txvector = '0; frame_len = '0;
    src_data = 8'h00; src_valid = 1'b0; scfm = 1'b0; data_cfm = 1'b1; ecfm = 1'b0;
    cfm_mode = 0; pat_ctr = 0; hold_cnt = 0; gap_at = 0; popped = 0; cur_len = 0;
    in_data = 0; p_in_data = 0; p_rdy = 0; took = 0;
    vec_seen = 0; data_seen = 0; src_taken = 0; end_seen = 0; done_seen = 0;

    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    check("rst_frame_val", 32'(frame_val), 32'h0);
    check("rst_txstart", 32'(txstart_req), 32'h0);
    check("rst_txend", 32'(txend_req), 32'h0);
    check("rst_busy", 32'(tx_busy), 32'h0);
    check("rst_done_err", 32'({tx_done, tx_err}), 32'h0);
    @(posedge wr_clk); #1 rst = 1'b0;

    run_frame(7,  0, 0,  0, 1);  // basic frame, confirm always high
    run_frame(20, 0, 0,  1, 2);  // confirm 7 high / 11 low
    run_frame(20, 0, 10, 0, 3);  // source gap of 3 cycles after byte 10
    run_frame(0,  0, 0,  0, 4);  // empty PSDU
    run_frame(10, 4, 0,  0, 5);  // abort during 4th data byte

`ifdef UU_WLAN_TX_TIMEOUT_EN
    begin
      int cyc;
      prep_frame(5, 6);
      exp_q.push_back({K_END, 8'h00});
      exp_q.push_back({K_ERR, 8'h00});
      pulse_tx_req();
      for (int n = 0; n < 200 && vec_seen < TXVEC_LEN; n++) @(posedge wr_clk);
      check("tmo_vec_bytes", 32'(vec_seen), 32'(TXVEC_LEN));
      cyc = 0;
      for (int n = 0; n < 200 && !end_seen; n++) begin
        @(posedge wr_clk);
        cyc++;
      end
      check("tmo_end_cycle", 32'(cyc), 32'd65);
      repeat (2) @(posedge wr_clk);
      #1 ecfm = 1'b1;
      @(posedge wr_clk); #1 ecfm = 1'b0;
      for (int n = 0; n < 10 && !done_seen; n++) @(posedge wr_clk);
      check("tmo_err_seen", 32'(done_seen), 32'h1);
    end
`else
    prep_frame(5, 6);
    pulse_tx_req();
    for (int n = 0; n < 200 && vec_seen < TXVEC_LEN; n++) @(posedge wr_clk);
    check("stuck_vec_bytes", 32'(vec_seen), 32'(TXVEC_LEN));
    repeat (10000) @(posedge wr_clk);
    @(negedge wr_clk);
    check("stuck_busy", 32'(tx_busy), 32'h1);
    check("stuck_state", 32'(state_dbg), 32'd2);
    check("stuck_no_end", 32'(end_seen), 32'h0);
    // asynchronous reset mid-frame discards it immediately
    @(posedge wr_clk); #1 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(tx_busy), 32'h0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_outs", 32'({txstart_req, frame_val, txend_req, tx_done, tx_err}), 32'h0);
    @(posedge wr_clk); #1 rst = 1'b0;
    repeat (3) @(posedge wr_clk);
`endif

    @(negedge wr_clk);
    check("final_exp_q", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uu_wlan_tx_frame_feeder.md
Name: uu_wlan_tx_frame_feeder

Overview:
- MAC-side transmit sequencer sitting directly upstream of the tx FIFO logic block, in the wr_clk domain.
- On a transmit request it latches a TXVECTOR and a byte count, then issues txstart_req and streams the TXVECTOR bytes.
- It then forwards PSDU bytes from a valid/ready byte source, one byte per granted txdata_confirm, and closes with txend_req.
- Completion is reported to the MAC control path with a tx_done / tx_err pulse.

Parameters:
TXVEC_LEN, 33, number of TXVECTOR bytes sent after txstart_req
LEN_W, 16, width of PSDU byte count
TIMEOUT_CYC, 4096, confirm watchdog limit in wr_clk cycles (only with optional feature)

Ports:
wr_clk  in  1  transmit-side clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
tx_req  in  1  1-cycle pulse, start a frame; ignored unless tx_busy=0
tx_abort  in  1  1-cycle pulse, terminate current frame
txvector  in  TXVEC_LEN*8  TXVECTOR bytes, byte 0 in bits [7:0]; sampled on tx_req
frame_len  in  LEN_W  PSDU byte count; sampled on tx_req
src_data  in  8  PSDU byte from MAC buffer
src_valid  in  1  src_data valid
src_ready  out  1  byte consumed this cycle (combinational)
fifo2mac_txstart_confirm  in  1  PHY accepted start
fifo2mac_txdata_confirm  in  1  permission to send one data byte
fifo2mac_txend_confirm  in  1  PHY finished
mac2fifo_txstart_req  out  1  start request pulse
mac2fifo_frame_val  out  1  mac2fifo_phy_frame valid
mac2fifo_phy_frame  out  8  TXVECTOR or PSDU byte
mac2fifo_txend_req  out  1  end request pulse
tx_busy  out  1  high in any state except IDLE
tx_done  out  1  1-cycle pulse, frame completed normally
tx_err  out  1  1-cycle pulse, frame aborted or timed out

Behaviour:
- All mac2fifo_* outputs, tx_done and tx_err are registered. All outputs are 0 in reset and in IDLE.
- Reset asserted mid-frame returns the block to IDLE immediately; any partial frame is discarded.
- States: IDLE, VEC, WAIT_SCFM, DATA, END, WAIT_ECFM.
- IDLE: on tx_req, latch txvector and frame_len into vec_reg/remain, clear byte index, go to VEC.
- VEC: lasts exactly TXVEC_LEN cycles.
  - First cycle: txstart_req=1, frame_val=1, phy_frame=byte 0.
  - Cycle i: frame_val=1, phy_frame=byte i; txstart_req=0 after the first cycle.
  - Then go to WAIT_SCFM.
- WAIT_SCFM: wait for txstart_confirm. On confirm, go to DATA if remain>0, otherwise go to END.
- DATA:
  - src_ready = (state==DATA) & fifo2mac_txdata_confirm & src_valid & (remain!=0).
  - On a src_ready cycle, the next cycle drives frame_val=1 with phy_frame=src_data, and remain decrements.
  - Confirm high with src_valid=0: stall; frame_val=0 next cycle; no byte is lost or duplicated.
  - Confirm low: frame_val=0 next cycle.
  - When the last byte is presented (remain reaches 0), go to END.
- END: one cycle with txend_req=1, frame_val=0, phy_frame=0; then WAIT_ECFM.
- WAIT_ECFM: on txend_confirm, pulse tx_done (or tx_err if the abort flag is set) and return to IDLE.
- tx_abort in VEC, WAIT_SCFM or DATA:
  - Set the abort flag, drop frame_val, go to END.
  - src_ready is forced low from the abort cycle onward.
  - tx_abort in IDLE, END or WAIT_ECFM is ignored.
- Confirms arriving in non-matching states are ignored.
- tx_req while busy is ignored; no queueing.
- Simultaneous tx_req and tx_abort in IDLE: tx_req wins.
- remain is LEN_W bits and never wraps; decrement occurs only when remain!=0.

Optional Feature:
- Macro UU_WLAN_TX_TIMEOUT_EN.
- Defined: a counter clears on every state entry and counts in WAIT_SCFM, WAIT_ECFM, and DATA while fifo2mac_txdata_confirm=0.
  - At TIMEOUT_CYC in WAIT_SCFM or DATA: set abort flag, go to END.
  - At TIMEOUT_CYC in WAIT_ECFM: pulse tx_err, go to IDLE.
- Undefined: no counter logic exists; all waits are unbounded.

Test Plan:
- TXVEC_LEN=33, frame_len=7, confirm always high after start -> txstart_req 1 cycle with byte 0; 33 consecutive frame_val cycles; 7 data bytes in order; one txend_req; tx_done after txend_confirm.
- txdata_confirm pattern high 7, low 11, repeated, frame_len=20 -> frame_val follows confirm one cycle later; exactly 20 bytes; no gaps while confirm is high.
- src_valid low for 3 cycles mid-DATA with confirm high -> frame_val=0 for those cycles; byte sequence intact; byte count still 20.
- frame_len=0 -> after txstart_confirm, txend_req next cycle; src_ready never asserted; tx_done.
- tx_abort at the 4th data byte -> frame_val drops; txend_req issued; tx_err (not tx_done) after txend_confirm; tx_req during WAIT_ECFM ignored.
- With UU_WLAN_TX_TIMEOUT_EN, TIMEOUT_CYC=64, txstart_confirm never driven -> txend_req at cycle 64 of WAIT_SCFM; tx_err after txend_confirm. Without the macro, the block stays in WAIT_SCFM for 10000 cycles.
